// File: rtl/axis_sync_pkt_fifo.sv
// Single-clock AXI-Stream FIFO carrying TLAST, with fill level, packet count,
// programmable almost-full/almost-empty flags and an optional store-and-forward mode.
module axis_sync_pkt_fifo #(
    parameter int unsigned AXIS_DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH        = 4,
    parameter bit          PACKET_MODE       = 1'b0,
    parameter int unsigned PROG_FULL_THRESH  = 12,
    parameter int unsigned PROG_EMPTY_THRESH = 2
) (
    input  logic                       aclk,
    input  logic                       rstn,
    input  logic [AXIS_DATA_WIDTH-1:0] wr_axis_data,
    input  logic                       wr_axis_last,
    input  logic                       wr_axis_vld,
    output logic                       wr_axis_rdy,
    output logic [AXIS_DATA_WIDTH-1:0] rd_axis_data,
    output logic                       rd_axis_last,
    output logic                       rd_axis_vld,
    input  logic                       rd_axis_rdy,
    output logic [ADDR_WIDTH:0]        level,
    output logic [ADDR_WIDTH:0]        pkt_count,
    output logic                       prog_full,
    output logic                       prog_empty
);

    localparam int unsigned         DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LP_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LP_FULL_TH  = PROG_FULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_EMPTY_TH = PROG_EMPTY_THRESH[ADDR_WIDTH:0];

    logic [AXIS_DATA_WIDTH:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH:0]        r_wr_ptr;
    logic [ADDR_WIDTH:0]        r_rd_ptr;
    logic [ADDR_WIDTH:0]        r_level;
    logic [ADDR_WIDTH:0]        r_pkt_count;
    logic [ADDR_WIDTH:0]        r_mem_pkts;
    logic                       r_wr_rdy;
    logic                       r_rd_vld;
    logic                       r_rd_last;
    logic                       r_mid_frame;
    logic [AXIS_DATA_WIDTH-1:0] r_rd_data;

    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic                       w_mem_empty;
    logic                       w_elig;
    logic                       w_load;
    logic                       w_head_last;
    logic [AXIS_DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH:0]        w_level_nxt;
    logic [ADDR_WIDTH:0]        w_pkt_nxt;
    logic [ADDR_WIDTH:0]        w_mem_pkts_nxt;

    function automatic logic [ADDR_WIDTH:0] f_upd(input logic [ADDR_WIDTH:0] v,
                                                  input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return v + LP_ONE;
            2'b01:   return v - LP_ONE;
            default: return v;
        endcase
    endfunction

    assign w_wr_acc    = wr_axis_vld & r_wr_rdy;
    assign w_rd_acc    = r_rd_vld & rd_axis_rdy;
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign {w_head_last, w_head_data} = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    // Store-and-forward gates on TLAST words still in memory (not the output
    // register), so a frame sitting in the output stage cannot release the
    // head of the following, still incomplete frame.
    always_comb begin
        w_elig = 1'b1;
        if (PACKET_MODE) begin
            w_elig = (r_mem_pkts != '0) | r_mid_frame |
                     ((r_level == LP_DEPTH) & (r_pkt_count == '0));
        end
    end

    assign w_load         = ~w_mem_empty & w_elig & (~r_rd_vld | rd_axis_rdy);
    assign w_level_nxt    = f_upd(r_level, w_wr_acc, w_rd_acc);
    assign w_pkt_nxt      = f_upd(r_pkt_count, w_wr_acc & wr_axis_last, w_rd_acc & r_rd_last);
    assign w_mem_pkts_nxt = f_upd(r_mem_pkts, w_wr_acc & wr_axis_last, w_load & w_head_last);

    always_ff @(posedge aclk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {wr_axis_last, wr_axis_data};
        end
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pkt_count <= '0;
            r_mem_pkts  <= '0;
            r_wr_rdy    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
            r_mid_frame <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_ONE;
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + LP_ONE;
                r_rd_data   <= w_head_data;
                r_rd_last   <= w_head_last;
                r_rd_vld    <= 1'b1;
                r_mid_frame <= ~w_head_last;
            end else if (w_rd_acc) begin
                r_rd_vld <= 1'b0;
            end
            r_level     <= w_level_nxt;
            r_pkt_count <= w_pkt_nxt;
            r_mem_pkts  <= w_mem_pkts_nxt;
            r_wr_rdy    <= (w_level_nxt < LP_DEPTH);
        end
    end

    assign wr_axis_rdy  = r_wr_rdy;
    assign rd_axis_data = r_rd_data;
    assign rd_axis_last = r_rd_last;
    assign rd_axis_vld  = r_rd_vld;
    assign level        = r_level;
    assign pkt_count    = r_pkt_count;
    assign prog_full    = (r_level >= LP_FULL_TH);
    assign prog_empty   = (r_level <= LP_EMPTY_TH);

endmodule

// File: tb/tb_axis_sync_pkt_fifo.sv
// Randomized and directed bench for axis_sync_pkt_fifo: one streaming instance and
// one store-and-forward instance, both checked against queue-based reference models.
module tb_axis_sync_pkt_fifo;

    logic        aclk;
    logic        rstn;

    logic [31:0] a_wdata, a_rdata, b_wdata, b_rdata;
    logic        a_wlast, a_wvld, a_wrdy, a_rlast, a_rvld, a_rrdy;
    logic        b_wlast, b_wvld, b_wrdy, b_rlast, b_rvld, b_rrdy;
    logic [4:0]  a_level, a_pkt, b_level, b_pkt;
    logic        a_pf, a_pe, b_pf, b_pe;

    axis_sync_pkt_fifo #(
        .AXIS_DATA_WIDTH(32), .ADDR_WIDTH(4), .PACKET_MODE(1'b0),
        .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)
    ) u_fifo (
        .aclk(aclk), .rstn(rstn),
        .wr_axis_data(a_wdata), .wr_axis_last(a_wlast), .wr_axis_vld(a_wvld), .wr_axis_rdy(a_wrdy),
        .rd_axis_data(a_rdata), .rd_axis_last(a_rlast), .rd_axis_vld(a_rvld), .rd_axis_rdy(a_rrdy),
        .level(a_level), .pkt_count(a_pkt), .prog_full(a_pf), .prog_empty(a_pe)
    );

    axis_sync_pkt_fifo #(
        .AXIS_DATA_WIDTH(32), .ADDR_WIDTH(4), .PACKET_MODE(1'b1),
        .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)
    ) u_pkt (
        .aclk(aclk), .rstn(rstn),
        .wr_axis_data(b_wdata), .wr_axis_last(b_wlast), .wr_axis_vld(b_wvld), .wr_axis_rdy(b_wrdy),
        .rd_axis_data(b_rdata), .rd_axis_last(b_rlast), .rd_axis_vld(b_rvld), .rd_axis_rdy(b_rrdy),
        .level(b_level), .pkt_count(b_pkt), .prog_full(b_pf), .prog_empty(b_pe)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic        a_exp_vld = 1'b0;
    int          a_reads = 0;
    int          b_reads = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int count_last(input logic [32:0] q[$]);
        int n = 0;
        foreach (q[i]) if (q[i][32]) n++;
        return n;
    endfunction

    // One clock: decide accepts from model state, advance models, check outputs #1 after the edge.
    task automatic cycle();
        bit wa, ra, wb, rb, hold_b;
        int la, lb;
        wa     = a_wvld && (qa.size() < 16);
        ra     = a_rrdy && a_exp_vld;
        wb     = b_wvld && (qb.size() < 16);
        rb     = b_rrdy && b_rvld;
        hold_b = b_rvld && !b_rrdy;
        if (a_rvld && a_rrdy) a_reads++;
        if (rb) b_reads++;
        @(posedge aclk);
        if (ra) void'(qa.pop_front());
        if (wa) qa.push_back({a_wlast, a_wdata});
        if (rb && qb.size() != 0) void'(qb.pop_front());
        if (wb) qb.push_back({b_wlast, b_wdata});
        #1;
        la = qa.size();
        lb = qb.size();
        a_exp_vld = (la - int'(wa)) > 0;
        check("a_vld",   a_rvld,  a_exp_vld);
        check("a_level", a_level, la);
        check("a_pkt",   a_pkt,   count_last(qa));
        check("a_wrdy",  a_wrdy,  la < 16);
        check("a_pfull", a_pf,    la >= 12);
        check("a_pempt", a_pe,    la <= 2);
        if (a_exp_vld) check("a_data", {a_rlast, a_rdata}, qa[0]);
        check("b_level", b_level, lb);
        check("b_pkt",   b_pkt,   count_last(qb));
        check("b_wrdy",  b_wrdy,  lb < 16);
        check("b_pfull", b_pf,    lb >= 12);
        check("b_pempt", b_pe,    lb <= 2);
        if (lb == 0) check("b_vld_empty", b_rvld, 1'b0);
        else if (b_rvld) check("b_data", {b_rlast, b_rdata}, qb[0]);
        if (hold_b) check("b_hold", b_rvld, 1'b1);
    endtask

    task automatic drain_a();
        a_wvld = 1'b0;
        a_rrdy = 1'b1;
        for (int n = 0; n < 40 && qa.size() != 0; n++) cycle();
        check("a_drained", a_level, 0);
    endtask

    initial begin
        int start;
        rstn = 1'b0;
        a_wdata = '0; a_wlast = 1'b0; a_wvld = 1'b0; a_rrdy = 1'b0;
        b_wdata = '0; b_wlast = 1'b0; b_wvld = 1'b0; b_rrdy = 1'b0;

        // Reset state, no clock edge yet
        #1;
        check("rst_a_vld",  a_rvld,  0);
        check("rst_a_data", a_rdata, 0);
        check("rst_a_last", a_rlast, 0);
        check("rst_a_lvl",  a_level, 0);
        check("rst_a_pkt",  a_pkt,   0);
        check("rst_a_pe",   a_pe,    1);
        check("rst_a_pf",   a_pf,    0);
        check("rst_b_vld",  b_rvld,  0);
        #12 rstn = 1'b1;
        cycle();
        check("rst_a_wrdy", a_wrdy, 1);

        // Fill to full with the reader stalled, then hold a 17th word
        for (int i = 0; i < 16; i++) begin
            a_wvld = 1'b1; a_wlast = (i == 7); a_wdata = i;
            cycle();
        end
        a_wdata = 32'd99;
        for (int i = 0; i < 3; i++) cycle();
        check("fill_level", a_level, 16);
        check("fill_wrdy",  a_wrdy,  0);

        // Random traffic until 1000 more words have been read
        start = a_reads;
        for (int n = 0; n < 8000 && (a_reads - start) < 1000; n++) begin
            a_wvld  = ($urandom % 4) != 0;
            a_wdata = $urandom;
            a_wlast = ($urandom % 4) == 0;
            a_rrdy  = $urandom % 2;
            cycle();
        end
        check("rand_reads", a_reads - start, 1000);
        drain_a();

        // Steady state at level 8
        a_rrdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_wvld = 1'b1; a_wlast = i[0]; a_wdata = 32'hA000 + i;
            cycle();
        end
        a_rrdy = 1'b1;
        start = a_reads;
        for (int i = 0; i < 20; i++) begin
            a_wdata = 32'hC000 + i; a_wlast = (i % 3) == 0;
            cycle();
            check("ss_level", a_level, 8);
        end
        check("ss_reads", a_reads - start, 20);
        drain_a();

        // Asynchronous reset mid-stream at level 5
        a_rrdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_wvld = 1'b1; a_wlast = (i == 2); a_wdata = 32'hD000 + i;
            cycle();
        end
        a_wvld = 1'b0;
        check("pre_rst_lvl", a_level, 5);
        #2 rstn = 1'b0;
        #1;
        check("arst_vld", a_rvld,  0);
        check("arst_lvl", a_level, 0);
        check("arst_pkt", a_pkt,   0);
        qa.delete(); qb.delete(); a_exp_vld = 1'b0;
        #1 rstn = 1'b1;
        cycle();
        start = a_reads;
        a_wvld = 1'b1; a_wlast = 1'b0; a_wdata = 32'h1234_5678; cycle();
        a_wlast = 1'b1; a_wdata = 32'h9ABC_DEF0; cycle();
        a_wvld = 1'b0; a_rrdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("post_rst_reads", a_reads - start, 2);

        // Store-and-forward: partial frame is held back
        b_rrdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_wvld = 1'b1; b_wlast = 1'b0; b_wdata = 32'hE000 + i;
            cycle();
            check("p5_hold", b_rvld, 0);
        end
        b_wvld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("p5_idle", b_rvld, 0);
        end
        b_wvld = 1'b1; b_wlast = 1'b1; b_wdata = 32'hE003;
        cycle();
        b_wvld = 1'b0;
        cycle();
        check("p5_pkt1", b_pkt, 1);
        start = b_reads;
        for (int k = 0; k < 4; k++) begin
            check("p5_vld",  b_rvld,  1);
            check("p5_last", b_rlast, k == 3);
            cycle();
        end
        check("p5_reads", b_reads - start, 4);
        check("p5_pkt0",  b_pkt,  0);
        check("p5_done",  b_rvld, 0);

        // Store-and-forward deadlock escape: full of a frame with no TLAST
        b_rrdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_wvld = 1'b1; b_wlast = 1'b0; b_wdata = 32'hF000 + i;
            cycle();
            check("p7_hold", b_rvld, 0);
        end
        b_wvld = 1'b0;
        cycle();
        check("p7_esc", b_rvld, 1);
        b_rrdy = 1'b1;
        start = b_reads;
        for (int i = 0; i < 16; i++) begin
            check("p7_cut", b_rvld,  1);
            check("p7_lvl", b_level, 16 - i);
            cycle();
        end
        check("p7_reads", b_reads - start, 16);
        check("p7_empty", b_rvld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
